// File: rtl/multi_project_switch.sv
// rtl/multi_project_switch.sv - project pad mux with isolate/reset switch sequencing and Wishbone regs
// Optional switch-done interrupt enabled by defining MPS_IRQ_EN.
module multi_project_switch #(
  parameter int          NUM_PROJECTS = 8,
  parameter int          IO_PADS      = 38,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          GUARD_CYCLES = 16
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_adr_i,
  input  logic [31:0]                     wbs_dat_i,
  output logic                            wbs_ack_o,
  output logic [31:0]                     wbs_dat_o,
  input  logic [IO_PADS-1:0]              io_in,
  output logic [IO_PADS-1:0]              io_out,
  output logic [IO_PADS-1:0]              io_oeb,
  input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out,
  output logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_in,
  output logic [NUM_PROJECTS-1:0]         proj_rst,
  output logic                            irq_o
);

  localparam int              CW         = $clog2(GUARD_CYCLES + 1);
  localparam logic [CW-1:0]   GUARD_LOAD = CW'(GUARD_CYCLES);
  localparam logic [8:0]      NP9        = 9'(NUM_PROJECTS);
  localparam logic [4:0]      NP5        = 5'(NUM_PROJECTS);
  localparam logic [7:0]      OFS_ACTIVE = 8'h00;
  localparam logic [7:0]      OFS_STATUS = 8'h0C;
  localparam logic [7:0]      OFS_ID     = 8'h10;
  localparam logic [31:0]     ID_WORD    = {8'(NUM_PROJECTS), 8'(IO_PADS), 16'h4D50};

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ISOLATE = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                   state;
  logic [7:0]               active;
  logic [7:0]               target;
  logic [CW-1:0]            counter;
  logic                     pads_on;
  logic [NUM_PROJECTS-1:0]  proj_rst_q;
  logic                     err;
  logic                     drop;
  logic                     irq_bit;
  logic                     ack_q;
  logic                     done;
  logic [31:0]              dat_q;
  logic [IO_PADS-1:0]       oeb [NUM_PROJECTS];

  logic                     valid;
  logic                     fire;
  logic                     wr;
  logic                     rd;
  logic                     rd_status;
  logic [7:0]               offset;
  logic [7:0]               oeb_rel;
  logic [3:0]               oeb_idx;
  logic                     oeb_hi;
  logic                     oeb_hit;
  logic [31:0]              status_word;
  logic [31:0]              rd_data;

  function automatic logic [NUM_PROJECTS-1:0] onehot(input logic [7:0] idx);
    logic [NUM_PROJECTS-1:0] v;
    v = '0;
    for (int p = 0; p < NUM_PROJECTS; p++)
      if (idx == 8'(p)) v[p] = 1'b1;
    return v;
  endfunction

  // One transaction per valid assertion: done holds off a second ack until valid drops.
  assign valid     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign fire      = valid & ~ack_q & ~done;
  assign wr        = fire & wbs_we_i;
  assign rd        = fire & ~wbs_we_i;
  assign offset    = wbs_adr_i[7:0];
  assign rd_status = rd & (offset == OFS_STATUS);

  // OEB window: 0x40 + 8*slot, +0 low word, +4 high word.
  assign oeb_rel = offset - 8'h40;
  assign oeb_idx = oeb_rel[6:3];
  assign oeb_hi  = oeb_rel[2];
  assign oeb_hit = (offset >= 8'h40) && !oeb_rel[7] && (offset[1:0] == 2'b00)
                   && ({1'b0, oeb_idx} < NP5);

  assign status_word = {16'd0, active, 2'd0, irq_bit, drop, err, (state != RUN), state};

  always_comb begin
    rd_data = '0;
    if (offset == OFS_ACTIVE) begin
      rd_data = {24'd0, active};
    end else if (offset == OFS_STATUS) begin
      rd_data = status_word;
    end else if (offset == OFS_ID) begin
      rd_data = ID_WORD;
    end else if (oeb_hit) begin
      for (int p = 0; p < NUM_PROJECTS; p++)
        if (oeb_idx == 4'(p))
          rd_data = oeb_hi ? {{(64-IO_PADS){1'b0}}, oeb[p][IO_PADS-1:32]} : oeb[p][31:0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ISOLATE;
      counter    <= GUARD_LOAD;
      active     <= '0;
      target     <= '0;
      pads_on    <= 1'b0;
      proj_rst_q <= '1;
      err        <= 1'b0;
      drop       <= 1'b0;
      ack_q      <= 1'b0;
      done       <= 1'b0;
      dat_q      <= '0;
      for (int p = 0; p < NUM_PROJECTS; p++) oeb[p] <= '1;
    end else begin
      ack_q <= fire;
      done  <= valid & (done | fire);
      dat_q <= rd ? rd_data : 32'd0;

      case (state)
        ISOLATE: begin
          if (counter == '0) begin
            active     <= target;
            proj_rst_q <= ~onehot(target);
            state      <= RELEASE;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        RELEASE: begin
          state   <= RUN;
          pads_on <= 1'b1;
        end
        default: ;
      endcase

      if (rd_status) begin
        err  <= 1'b0;
        drop <= 1'b0;
      end

      // Switch requests are only honoured from RUN; anything mid-switch is dropped.
      if (wr && offset == OFS_ACTIVE) begin
        if (state != RUN) begin
          drop <= 1'b1;
        end else if ({1'b0, wbs_dat_i[7:0]} >= NP9) begin
          err <= 1'b1;
        end else begin
          target     <= wbs_dat_i[7:0];
          counter    <= GUARD_LOAD;
          state      <= ISOLATE;
          pads_on    <= 1'b0;
          proj_rst_q <= '1;
        end
      end

      if (wr && oeb_hit && wbs_sel_i == 4'hF) begin
        for (int p = 0; p < NUM_PROJECTS; p++)
          if (oeb_idx == 4'(p)) begin
            if (oeb_hi) oeb[p][IO_PADS-1:32] <= wbs_dat_i[IO_PADS-33:0];
            else        oeb[p][31:0]         <= wbs_dat_i;
          end
      end
    end
  end

`ifdef MPS_IRQ_EN
  logic irq_pend;
  logic boot_switch;

  // The switch started by reset completes silently; the set beats a same-edge read-clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_pend    <= 1'b0;
      boot_switch <= 1'b1;
    end else begin
      if (rd_status) irq_pend <= 1'b0;
      if (state == RELEASE) begin
        if (!boot_switch) irq_pend <= 1'b1;
        boot_switch <= 1'b0;
      end
    end
  end

  assign irq_bit = irq_pend;
  assign irq_o   = irq_pend;
`else
  assign irq_bit = 1'b0;
  assign irq_o   = 1'b0;
`endif

  always_comb begin
    io_out     = '0;
    io_oeb     = '1;
    proj_io_in = '0;
    for (int p = 0; p < NUM_PROJECTS; p++) begin
      if (pads_on && active == 8'(p)) begin
        io_out                         = proj_io_out[p*IO_PADS +: IO_PADS];
        io_oeb                         = oeb[p];
        proj_io_in[p*IO_PADS +: IO_PADS] = io_in;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign proj_rst  = proj_rst_q;

endmodule

// File: tb/tb_multi_project_switch.sv
// tb/tb_multi_project_switch.sv - self-checking bench for multi_project_switch
// Honours MPS_IRQ_EN when defined for the build.
module tb_multi_project_switch;

  localparam int          NP   = 8;
  localparam int          IO   = 38;
  localparam int          G    = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef MPS_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]        sel = 4'h0;
  logic [31:0]       adr = '0, wdat = '0;
  logic              ack;
  logic [31:0]       rdat;
  logic [IO-1:0]     io_in = '0;
  logic [IO-1:0]     io_out, io_oeb;
  logic [NP*IO-1:0]  proj_io_out = '0;
  logic [NP*IO-1:0]  proj_io_in;
  logic [NP-1:0]     proj_rst;
  logic              irq;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [IO-1:0] m_oeb [NP];
  bit m_err = 0, m_drop = 0, m_irq = 0;

  multi_project_switch #(
    .NUM_PROJECTS(NP), .IO_PADS(IO), .BASE_ADDR(BASE), .GUARD_CYCLES(G)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .proj_io_out(proj_io_out), .proj_io_in(proj_io_in),
    .proj_rst(proj_rst), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_status(input int st, input int act);
    return {16'd0, 8'(act), 2'd0, m_irq, m_drop, m_err, (st != 0), 2'(st)};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) m_oeb[p] = '1;
    m_err = 0; m_drop = 0; m_irq = 0;
  endtask

  // Wishbone transfer; afterwards leaves one idle edge so the next transfer is a fresh one.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit expect_ack,
                         output logic [31:0] data, output int ack_edge);
    int n;
    bit got;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    got = 0; n = 0; data = '0; ack_edge = -1;
    while (!got && n < 4) begin
      @(posedge clk); #1; n++;
      if (ack) begin got = 1; data = rdat; ack_edge = cyc_cnt; end
    end
    cyc = 0; stb = 0; we = 0;
    checks++;
    if (got !== expect_ack || (got && n != 1) || (got && w && data !== 32'd0)) begin
      errors++;
      $display("FAIL wb_ack adr=%h we=%b: ack=%0d after %0d clocks dat=%h, required ack=%0d after 1 clock",
               a, w, got, n, data, expect_ack);
    end
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [31:0] ofs, input logic [31:0] d, output int e);
    logic [31:0] dummy;
    wb_xfer(1'b1, BASE + ofs, d, 4'hF, 1'b1, dummy, e);
  endtask

  task automatic wb_read(input logic [31:0] ofs, output logic [31:0] d, output int e);
    wb_xfer(1'b0, BASE + ofs, 32'd0, 4'hF, 1'b1, d, e);
  endtask

  // k = clock edges since the switch was started (ack edge or last reset edge).
  task automatic check_pads(input string tag, input int k, input int act, input bit sets_irq);
    logic [IO-1:0]    e_out, e_oeb;
    logic [NP*IO-1:0] e_in;
    logic [NP-1:0]    e_rst;
    logic             e_irq;
    bit               run;
    for (int i = 0; i < NP*IO; i++) proj_io_out[i] = 1'($urandom);
    for (int i = 0; i < IO; i++) io_in[i] = 1'($urandom);
    #1;
    run   = (k >= G + 2);
    e_rst = '1;
    if (k > G) e_rst[act] = 1'b0;
    e_out = run ? proj_io_out[act*IO +: IO] : '0;
    e_oeb = run ? m_oeb[act] : '1;
    e_in  = '0;
    if (run) e_in[act*IO +: IO] = io_in;
    e_irq = m_irq | (IRQ_EN & sets_irq & run);
    checks++;
    if (io_out !== e_out || io_oeb !== e_oeb || proj_io_in !== e_in || proj_rst !== e_rst || irq !== e_irq) begin
      errors++;
      $display("FAIL pads_%s k=%0d: out=%h oeb=%h rst=%h irq=%b in_ok=%0d, required out=%h oeb=%h rst=%h irq=%b",
               tag, k, io_out, io_oeb, proj_rst, irq, (proj_io_in === e_in), e_out, e_oeb, e_rst, e_irq);
    end
  endtask

  task automatic watch(input string tag, input int start, input int act, input bit sets_irq);
    while (cyc_cnt < start + G + 4) begin
      check_pads(tag, cyc_cnt - start, act, sets_irq);
      @(posedge clk); #1;
    end
    if (sets_irq && IRQ_EN) m_irq = 1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int e, r;
    model_reset();
    @(negedge clk); rst = 1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0 || rdat !== 32'd0 || io_out !== '0 || io_oeb !== '1 || proj_rst !== '1 || irq !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: ack=%b dat=%h out=%h oeb=%h rst=%h irq=%b, required 0 0 0 all1 all1 0",
                 ack, rdat, io_out, io_oeb, proj_rst, irq);
      end
    end
    r = cyc_cnt;
    rst = 0;
    wb_read(32'h0C, d, e);
    checks++;
    if (d !== exp_status(1, 0)) begin
      errors++; $display("FAIL reset_status_busy: got %h, required %h", d, exp_status(1, 0));
    end
    watch("boot", r, 0, 1'b0);
    wb_read(32'h0C, d, e);
    checks++;
    if (d !== exp_status(0, 0)) begin
      errors++; $display("FAIL boot_status_run: got %h, required %h", d, exp_status(0, 0));
    end
    wb_read(32'h10, d, e);
    checks++;
    if (d !== {8'(NP), 8'(IO), 16'h4D50}) begin
      errors++; $display("FAIL id: got %h, required %h", d, {8'(NP), 8'(IO), 16'h4D50});
    end
  endtask

  task automatic test_switch();
    logic [31:0] d;
    int e;
    wb_write(32'h40 + 8*3, 32'd0, e);
    m_oeb[3][31:0] = '0;
    wb_write(32'h00, 32'd3, e);
    watch("to3", e, 3, 1'b1);
    wb_read(32'h0C, d, e);
    checks++;
    if (d !== exp_status(0, 3)) begin
      errors++; $display("FAIL switch3_status: got %h, required %h", d, exp_status(0, 3));
    end
    m_irq = 0;
  endtask

  task automatic test_bad_index();
    logic [31:0] d;
    int e;
    wb_write(32'h00, 32'd9, e);
    m_err = 1;
    check_pads("bad_index", 1000, 3, 1'b0);
    wb_read(32'h0C, d, e);
    checks++;
    if (d !== exp_status(0, 3)) begin
      errors++; $display("FAIL err_set: got %h, required %h", d, exp_status(0, 3));
    end
    m_err = 0;
    wb_read(32'h0C, d, e);
    checks++;
    if (d !== exp_status(0, 3)) begin
      errors++; $display("FAIL err_cleared: got %h, required %h", d, exp_status(0, 3));
    end
  endtask

  task automatic test_drop();
    logic [31:0] d;
    int e, e2;
    wb_write(32'h00, 32'd5, e);
    wb_write(32'h00, 32'd2, e2);
    m_drop = 1;
    while (cyc_cnt < e + G + 3) begin @(posedge clk); #1; end
    m_irq = IRQ_EN;
    check_pads("after_drop", cyc_cnt - e, 5, 1'b0);
    wb_read(32'h0C, d, e);
    checks++;
    if (d !== exp_status(0, 5)) begin
      errors++; $display("FAIL drop_status: got %h, required %h", d, exp_status(0, 5));
    end
    m_drop = 0; m_irq = 0;
  endtask

  task automatic test_oeb_random();
    logic [31:0] d, v, ex;
    logic [3:0]  s;
    int e, slot;
    bit hi;
    for (int i = 0; i < 12; i++) begin
      slot = $urandom_range(0, NP - 1);
      hi   = 1'($urandom);
      v    = $urandom;
      s    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      wb_xfer(1'b1, BASE + 32'h40 + 32'(8*slot) + (hi ? 32'd4 : 32'd0), v, s, 1'b1, d, e);
      if (s == 4'hF) begin
        if (hi) m_oeb[slot][IO-1:32] = v[IO-33:0];
        else    m_oeb[slot][31:0]    = v;
      end
      wb_read(32'h40 + 32'(8*slot) + (hi ? 32'd4 : 32'd0), d, e);
      ex = hi ? {{(64-IO){1'b0}}, m_oeb[slot][IO-1:32]} : m_oeb[slot][31:0];
      checks++;
      if (d !== ex) begin
        errors++; $display("FAIL oeb_rw slot=%0d hi=%0d sel=%h: got %h, required %h", slot, hi, s, d, ex);
      end
    end
    check_pads("oeb_active5", 1000, 5, 1'b0);
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    int e;
    wb_read(32'h04, d, e);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h, required 0", d); end
    wb_read(32'h40 + 8*NP, d, e);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL oeb_beyond_slots: got %h, required 0", d); end
    wb_xfer(1'b1, BASE + 32'h100, 32'd1, 4'hF, 1'b0, d, e);
    check_pads("outside_window", 1000, 5, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int e, r;
    wb_write(32'h00, 32'd1, e);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    r = cyc_cnt;
    rst = 0;
    model_reset();
    wb_read(32'h0C, d, e);
    checks++;
    if (d !== exp_status(1, 0)) begin
      errors++; $display("FAIL midreset_status: got %h, required %h", d, exp_status(1, 0));
    end
    watch("midreset", r, 0, 1'b0);
    wb_read(32'h40 + 8*3, d, e);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midreset_oeb_lo: got %h, required ffffffff", d); end
    wb_read(32'h44 + 8*3, d, e);
    checks++;
    if (d !== 32'((64'd1 << (IO - 32)) - 1)) begin
      errors++; $display("FAIL midreset_oeb_hi: got %h, required %h", d, 32'((64'd1 << (IO - 32)) - 1));
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int e, e2;
    wb_write(32'h00, 32'd1, e);
    while (cyc_cnt < e + G + 1) begin @(posedge clk); #1; end
    wb_read(32'h0C, d, e2);
    checks++;
    if (d !== exp_status(2, 1) || e2 !== e + G + 2) begin
      errors++; $display("FAIL release_status: got %h at edge %0d, required %h at edge %0d", d, e2 - e, exp_status(2, 1), G + 2);
    end
    m_irq = IRQ_EN;
    wb_read(32'h0C, d, e2);
    checks++;
    if (d !== exp_status(0, 1) || irq !== 1'b0) begin
      errors++; $display("FAIL irq_status_clear: got %h irq=%b, required %h irq=0", d, irq, exp_status(0, 1));
    end
    m_irq = 0;
  endtask

  task automatic test_back_to_back_hold();
    logic [31:0] d;
    int n;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h10; sel = 4'hF;
    n = 0; d = '0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack) begin n++; d = rdat; end
    end
    cyc = 0; stb = 0;
    checks++;
    if (n !== 1 || d !== {8'(NP), 8'(IO), 16'h4D50}) begin
      errors++; $display("FAIL hold_single_ack: acks=%0d dat=%h, required 1 ack dat=%h", n, d, {8'(NP), 8'(IO), 16'h4D50});
    end
    @(posedge clk); #1;
    check_pads("final", 1000, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_switch();
    test_bad_index();
    test_drop();
    test_oeb_random();
    test_unmapped();
    test_reset_mid();
    test_irq();
    test_back_to_back_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
